// File: rtl/cp0_reg_if.sv
// Write-back to CP0 bundle: MTC0 commit plus the exception state of the committing instruction.
interface cp0_reg_if;
    logic        cp0_wr;
    logic [4:0]  dst;
    logic [31:0] result;
    logic [8:0]  except_type;
    logic [31:0] pc;
    logic        in_delay_slot;
    logic [31:0] alu_out;

    modport master (
        output cp0_wr, dst, result, except_type, pc, in_delay_slot, alu_out
    );

    modport slave (
        input cp0_wr, dst, result, except_type, pc, in_delay_slot, alu_out
    );
endinterface

// File: rtl/cp0_reg.sv
// MIPS CP0 subset: BadVAddr, Count, Compare, Status, Cause, EPC, with exception
// commit, Eret redirect, timer interrupt and interrupt-request generation.
module cp0_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic [5:0]  Ext_Int,
    input  logic        WB_CP0Wr,
    input  logic [4:0]  WB_Dst,
    input  logic [31:0] WB_Result,
    input  logic [8:0]  WB_ExceptType,
    input  logic [31:0] WB_PC,
    input  logic        WB_IsInDelaySlot,
    input  logic [31:0] WB_ALUOut,
    input  logic [4:0]  CP0_RdAddr,
    output logic [31:0] CP0_RdData,
    output logic        CP0_IntReq,
    output logic        CP0_Flush,
    output logic [31:0] CP0_ExceptPC
);
    // ExceptinPipeType bit positions, Interrupt in the MSB down to RdWrongAddressinMEM in the LSB
    localparam int E_INT   = 8;
    localparam int E_IFADR = 7;
    localparam int E_RI    = 6;
    localparam int E_OV    = 5;
    localparam int E_SYS   = 4;
    localparam int E_BRK   = 3;
    localparam int E_ERET  = 2;
    localparam int E_WRADR = 1;
    localparam int E_RDADR = 0;

    localparam logic [4:0] REG_BADVADDR = 5'd8;
    localparam logic [4:0] REG_COUNT    = 5'd9;
    localparam logic [4:0] REG_COMPARE  = 5'd11;
    localparam logic [4:0] REG_STATUS   = 5'd12;
    localparam logic [4:0] REG_CAUSE    = 5'd13;
    localparam logic [4:0] REG_EPC      = 5'd14;

    localparam logic [31:0] EXC_VECTOR = 32'hBFC0_0380;

    // Writable register numbers, one write-select bit each (index 0 = last in the list)
    localparam int NUM_WR = 5;
    localparam logic [5*NUM_WR-1:0] WR_REGS = {REG_COUNT, REG_COMPARE, REG_STATUS, REG_CAUSE, REG_EPC};
    localparam int WS_EPC     = 0;
    localparam int WS_CAUSE   = 1;
    localparam int WS_STATUS  = 2;
    localparam int WS_COMPARE = 3;
    localparam int WS_COUNT   = 4;

    logic [31:0] badvaddr_reg;
    logic [31:0] count_reg;
    logic [31:0] compare_reg;
    logic [31:0] epc_reg;
    logic [7:0]  status_im_reg;
    logic        status_exl_reg;
    logic        status_ie_reg;
    logic        cause_bd_reg;
    logic        cause_ti_reg;
    logic [5:0]  cause_iphw_reg;
    logic [1:0]  cause_ipsw_reg;
    logic [4:0]  cause_exccode_reg;
    logic        tick_reg;

    logic [8:0]  exc_bits;
    logic        exc_any;
    logic        eret_only;
    logic [4:0]  exc_code_next;
    logic        badv_load;
    logic [31:0] badv_next;
    logic        mtc0_en;
    logic [NUM_WR-1:0] wr_sel;
    logic [31:0] status_value;
    logic [31:0] cause_value;

    // Eret is a redirect, not an exception; it only acts when nothing else is raised
    assign exc_bits  = WB_ExceptType & ~(9'b1 << E_ERET);
    assign exc_any   = |exc_bits;
    assign eret_only = WB_ExceptType[E_ERET] & ~exc_any;

    always_comb begin
        exc_code_next = 5'h00;
        badv_load     = 1'b0;
        badv_next     = WB_ALUOut;
        if (exc_bits[E_INT]) begin
            exc_code_next = 5'h00;
        end else if (exc_bits[E_IFADR]) begin
            exc_code_next = 5'h04;
            badv_load     = 1'b1;
            badv_next     = WB_PC;
        end else if (exc_bits[E_RI]) begin
            exc_code_next = 5'h0a;
        end else if (exc_bits[E_OV]) begin
            exc_code_next = 5'h0c;
        end else if (exc_bits[E_SYS]) begin
            exc_code_next = 5'h08;
        end else if (exc_bits[E_BRK]) begin
            exc_code_next = 5'h09;
        end else if (exc_bits[E_RDADR]) begin
            exc_code_next = 5'h04;
            badv_load     = 1'b1;
        end else if (exc_bits[E_WRADR]) begin
            exc_code_next = 5'h05;
            badv_load     = 1'b1;
        end
    end

    always_comb begin
        CP0_Flush    = 1'b0;
        CP0_ExceptPC = 32'h0;
        if (!rst) begin
            if (exc_any) begin
                CP0_Flush    = 1'b1;
                CP0_ExceptPC = EXC_VECTOR;
            end else if (eret_only) begin
                CP0_Flush    = 1'b1;
                CP0_ExceptPC = epc_reg;
            end
        end
    end

    // A redirecting instruction's MTC0 never commits
    assign mtc0_en = WB_CP0Wr & ~CP0_Flush;

    generate
        for (genvar gi = 0; gi < NUM_WR; gi++) begin : g_wr_sel
            assign wr_sel[gi] = mtc0_en && (WB_Dst == WR_REGS[gi*5 +: 5]);
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            badvaddr_reg      <= 32'h0;
            count_reg         <= 32'h0;
            compare_reg       <= 32'h0;
            epc_reg           <= 32'h0;
            status_im_reg     <= 8'h0;
            status_exl_reg    <= 1'b0;
            status_ie_reg     <= 1'b0;
            cause_bd_reg      <= 1'b0;
            cause_ti_reg      <= 1'b0;
            cause_iphw_reg    <= 6'h0;
            cause_ipsw_reg    <= 2'h0;
            cause_exccode_reg <= 5'h0;
            tick_reg          <= 1'b0;
        end else begin
            tick_reg       <= ~tick_reg;
            cause_iphw_reg <= {Ext_Int[5] | cause_ti_reg, Ext_Int[4:0]};

            if (wr_sel[WS_COUNT]) begin
                count_reg <= WB_Result;
            end else if (tick_reg) begin
                count_reg <= count_reg + 32'd1;
            end

            if (wr_sel[WS_COMPARE]) begin
                compare_reg  <= WB_Result;
                cause_ti_reg <= 1'b0;
            end else if (count_reg == compare_reg) begin
                cause_ti_reg <= 1'b1;
            end

            if (wr_sel[WS_STATUS]) begin
                status_im_reg  <= WB_Result[15:8];
                status_exl_reg <= WB_Result[1];
                status_ie_reg  <= WB_Result[0];
            end

            if (wr_sel[WS_CAUSE]) begin
                cause_ipsw_reg <= WB_Result[9:8];
            end

            if (wr_sel[WS_EPC]) begin
                epc_reg <= WB_Result;
            end

            // Nested exceptions (EXL already set) keep the original EPC and BD
            if (exc_any) begin
                status_exl_reg    <= 1'b1;
                cause_exccode_reg <= exc_code_next;
                if (!status_exl_reg) begin
                    epc_reg      <= WB_IsInDelaySlot ? (WB_PC - 32'd4) : WB_PC;
                    cause_bd_reg <= WB_IsInDelaySlot;
                end
                if (badv_load) begin
                    badvaddr_reg <= badv_next;
                end
            end else if (eret_only) begin
                status_exl_reg <= 1'b0;
            end
        end
    end

    assign status_value = {9'b0, 1'b1, 6'b0, status_im_reg, 6'b0, status_exl_reg, status_ie_reg};
    assign cause_value  = {cause_bd_reg, cause_ti_reg, 14'b0, cause_iphw_reg, cause_ipsw_reg,
                           1'b0, cause_exccode_reg, 2'b0};

    always_comb begin
        CP0_RdData = 32'h0;
        case (CP0_RdAddr)
            REG_BADVADDR: CP0_RdData = badvaddr_reg;
            REG_COUNT:    CP0_RdData = count_reg;
            REG_COMPARE:  CP0_RdData = compare_reg;
            REG_STATUS:   CP0_RdData = status_value;
            REG_CAUSE:    CP0_RdData = cause_value;
            REG_EPC:      CP0_RdData = epc_reg;
            default:      CP0_RdData = 32'h0;
        endcase
    end

    assign CP0_IntReq = ~rst & status_ie_reg & ~status_exl_reg &
                        (|({cause_iphw_reg, cause_ipsw_reg} & status_im_reg));
endmodule

// File: tb/tb_cp0_reg.sv
// Self-checking bench for cp0_reg: vector table with a readback scoreboard plus
// hand-written reset, timer, counter-wrap and external-interrupt sequences.
module tb_cp0_reg;
    localparam logic [8:0] E_INT   = 9'h100;
    localparam logic [8:0] E_IFADR = 9'h080;
    localparam logic [8:0] E_RI    = 9'h040;
    localparam logic [8:0] E_OV    = 9'h020;
    localparam logic [8:0] E_SYS   = 9'h010;
    localparam logic [8:0] E_BRK   = 9'h008;
    localparam logic [8:0] E_ERET  = 9'h004;
    localparam logic [8:0] E_WRADR = 9'h002;
    localparam logic [8:0] E_RDADR = 9'h001;
    localparam logic [31:0] XV     = 32'hBFC0_0380;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [5:0]  ext_int = 6'h0;
    logic [4:0]  rd_addr = 5'h0;
    logic [31:0] rd_data;
    logic        int_req;
    logic        flush;
    logic [31:0] except_pc;

    cp0_reg_if wb ();

    cp0_reg dut (
        .clk              (clk),
        .rst              (rst),
        .Ext_Int          (ext_int),
        .WB_CP0Wr         (wb.cp0_wr),
        .WB_Dst           (wb.dst),
        .WB_Result        (wb.result),
        .WB_ExceptType    (wb.except_type),
        .WB_PC            (wb.pc),
        .WB_IsInDelaySlot (wb.in_delay_slot),
        .WB_ALUOut        (wb.alu_out),
        .CP0_RdAddr       (rd_addr),
        .CP0_RdData       (rd_data),
        .CP0_IntReq       (int_req),
        .CP0_Flush        (flush),
        .CP0_ExceptPC     (except_pc)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        wr;
        logic [4:0]  dst;
        logic [31:0] data;
        logic [8:0]  et;
        logic [31:0] pc;
        logic        ds;
        logic [31:0] alu;
        logic        xflush;
        logic [31:0] xpc;
        logic [4:0]  rd;
        logic [31:0] rdv;
        logic        xint;
    } vec_t;

    typedef struct {
        int          idx;
        logic [4:0]  rd;
        logic [31:0] val;
        logic        xint;
    } exp_t;

    vec_t vecs[$];
    exp_t sb[$];
    int   n_checks = 0;
    int   n_pass   = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %08h expected %08h", nm, act, exp);
    endtask

    task automatic add(input logic wr, input logic [4:0] dst, input logic [31:0] data,
                       input logic [8:0] et, input logic [31:0] pc, input logic ds,
                       input logic [31:0] alu, input logic xflush, input logic [31:0] xpc,
                       input logic [4:0] rd, input logic [31:0] rdv, input logic xint);
        vec_t v;
        v.wr = wr; v.dst = dst; v.data = data; v.et = et; v.pc = pc; v.ds = ds; v.alu = alu;
        v.xflush = xflush; v.xpc = xpc; v.rd = rd; v.rdv = rdv; v.xint = xint;
        vecs.push_back(v);
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wb.cp0_wr = 1'b0; wb.dst = 5'h0; wb.result = 32'h0; wb.except_type = 9'h0;
        wb.pc = 32'h0; wb.in_delay_slot = 1'b0; wb.alu_out = 32'h0;
    endtask

    task automatic mtc0(input logic [4:0] d, input logic [31:0] v);
        cyc();
        idle();
        wb.cp0_wr = 1'b1; wb.dst = d; wb.result = v;
    endtask

    task automatic rd(input logic [4:0] a, output logic [31:0] v);
        cyc();
        idle();
        rd_addr = a;
        #1 v = rd_data;
    endtask

    logic [31:0] v;
    int          wait_n;
    bit          seen;

    initial begin
        idle();
        // Vectors: inputs for one cycle, redirect expected that cycle, readback after the edge
        add(1, 12, 32'h0000FF01, 0, 0, 0, 0, 0, 0, 12, 32'h0040FF01, 0);
        add(1, 14, 32'h12345678, 0, 0, 0, 0, 0, 0, 14, 32'h12345678, 0);
        add(1,  8, 32'hDEADBEEF, 0, 0, 0, 0, 0, 0,  8, 32'h0, 0);
        add(1, 13, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 13, 32'h00000300, 1);
        add(1, 13, 32'h0,        0, 0, 0, 0, 0, 0, 13, 32'h0, 0);
        add(0,  0, 0,            0, 0, 0, 0, 0, 0, 10, 32'h0, 0);
        add(0, 0, 0, E_SYS, 32'hBFC00100, 0, 0, 1, XV, 14, 32'hBFC00100, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h00000020, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 12, 32'h0040FF03, 0);
        add(0, 0, 0, E_ERET, 0, 0, 0, 1, 32'hBFC00100, 12, 32'h0040FF01, 0);
        add(0, 0, 0, E_RDADR, 32'hBFC00204, 1, 32'h3, 1, XV, 8, 32'h3, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 32'hBFC00200, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h80000010, 0);
        add(0, 0, 0, E_OV, 32'h11111110, 0, 0, 1, XV, 14, 32'hBFC00200, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h80000030, 0);
        add(0, 0, 0, E_ERET, 0, 0, 0, 1, 32'hBFC00200, 12, 32'h0040FF01, 0);
        add(1, 13, 32'h300, E_BRK, 32'h40, 0, 0, 1, XV, 13, 32'h00000024, 0);
        add(0, 0, 0, E_ERET, 0, 0, 0, 1, 32'h40, 12, 32'h0040FF01, 0);
        add(0, 0, 0, E_IFADR | E_SYS | E_ERET, 32'h101, 0, 0, 1, XV, 8, 32'h101, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h00000010, 0);
        add(0, 0, 0, E_ERET, 0, 0, 0, 1, 32'h101, 12, 32'h0040FF01, 0);
        add(0, 0, 0, E_WRADR, 32'h300, 0, 32'h20000007, 1, XV, 8, 32'h20000007, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 13, 32'h00000014, 0);
        add(0, 0, 0, E_ERET, 0, 0, 0, 1, 32'h300, 12, 32'h0040FF01, 0);
        add(0, 0, 0, E_INT | E_RI, 32'h400, 0, 0, 1, XV, 13, 32'h0, 0);
        add(0, 0, 0, 0, 0, 0, 0, 0, 0, 14, 32'h400, 0);
        add(0, 0, 0, E_RI, 32'h500, 0, 0, 1, XV, 13, 32'h00000028, 0);
        add(1, 12, 32'h0, E_ERET, 0, 0, 0, 1, 32'h400, 12, 32'h0040FF01, 0);
        add(1, 11, 32'hFFFFFFFF, 0, 0, 0, 0, 0, 0, 11, 32'hFFFFFFFF, 0);
        add(1, 5, 32'hAAAA5555, 0, 0, 0, 0, 0, 0, 5, 32'h0, 0);

        // Reset held while a syscall and an MTC0 are presented
        wb.except_type = E_SYS; wb.pc = 32'h1234; wb.cp0_wr = 1'b1; wb.dst = 5'd12;
        wb.result = 32'hFFFFFFFF;
        repeat (3) cyc();
        #2;
        chk("rst_flush", {31'b0, flush}, 32'h0);
        chk("rst_xpc", except_pc, 32'h0);
        chk("rst_intreq", {31'b0, int_req}, 32'h0);
        // Leave reset with a far-away Compare so the timer stays quiet during the table
        cyc();
        rst = 1'b0;
        idle();
        wb.cp0_wr = 1'b1; wb.dst = 5'd11; wb.result = 32'hFFFFFFFF;
        rd(12, v); chk("reset_status", v, 32'h00400000);
        rd(13, v); chk("reset_cause", v, 32'h0);
        rd(14, v); chk("reset_epc", v, 32'h0);

        foreach (vecs[i]) begin
            exp_t e;
            cyc();
            wb.cp0_wr = vecs[i].wr; wb.dst = vecs[i].dst; wb.result = vecs[i].data;
            wb.except_type = vecs[i].et; wb.pc = vecs[i].pc; wb.in_delay_slot = vecs[i].ds;
            wb.alu_out = vecs[i].alu;
            #3;
            chk($sformatf("vec%0d_flush", i), {31'b0, flush}, {31'b0, vecs[i].xflush});
            chk($sformatf("vec%0d_xpc", i), except_pc, vecs[i].xpc);
            e.idx = i; e.rd = vecs[i].rd; e.val = vecs[i].rdv; e.xint = vecs[i].xint;
            sb.push_back(e);
            cyc();
            idle();
            rd_addr = sb[0].rd;
            #1;
            e = sb.pop_front();
            chk($sformatf("vec%0d_rd%0d", e.idx, e.rd), rd_data, e.val);
            chk($sformatf("vec%0d_intreq", e.idx), {31'b0, int_req}, {31'b0, e.xint});
        end

        // External interrupt lines land in Cause.IP one cycle after they are seen
        cyc();
        idle();
        ext_int = 6'h21;
        cyc();
        rd(13, v); chk("ext_ip", v & 32'h0000FC00, 32'h00008400);
        chk("ext_intreq", {31'b0, int_req}, 32'h1);
        ext_int = 6'h0;
        cyc();
        rd(13, v); chk("ext_ip_clear", v & 32'h0000FC00, 32'h0);
        chk("ext_intreq_clear", {31'b0, int_req}, 32'h0);

        // Count runs at half the clock rate and wraps
        mtc0(9, 32'hFFFFFFFE);
        rd(9, v); chk("count_write", v, 32'hFFFFFFFE);
        cyc();
        rd(9, v); chk("count_inc", v, 32'hFFFFFFFF);
        cyc();
        rd(9, v); chk("count_wrap", v, 32'h0);

        // Timer interrupt through Compare match, cleared by rewriting Compare
        mtc0(9, 32'h0);
        mtc0(11, 32'h4);
        mtc0(12, 32'h00008001);
        cyc();
        idle();
        rd_addr = 5'd13;
        #1;
        chk("timer_not_early", {31'b0, int_req}, 32'h0);
        seen = 1'b0;
        wait_n = 0;
        for (int k = 0; k < 30 && !seen; k++) begin
            cyc();
            wait_n++;
            if (int_req) seen = 1'b1;
        end
        chk("timer_intreq", {31'b0, seen}, 32'h1);
        chk("timer_latency_ok", {31'b0, (wait_n >= 3 && wait_n <= 12)}, 32'h1);
        #1;
        chk("timer_ti", rd_data & 32'h40000000, 32'h40000000);
        mtc0(11, 32'hFFFFFFFF);
        rd(13, v); chk("timer_ti_clear", v & 32'h40000000, 32'h0);
        cyc();
        #1;
        chk("timer_intreq_clear", {31'b0, int_req}, 32'h0);

        // Reset arriving while an exception is being committed
        cyc();
        wb.except_type = E_SYS; wb.pc = 32'h00001234;
        #2;
        chk("pre_rst_flush", {31'b0, flush}, 32'h1);
        rst = 1'b1;
        #1;
        chk("mid_rst_flush", {31'b0, flush}, 32'h0);
        chk("mid_rst_xpc", except_pc, 32'h0);
        cyc();
        rst = 1'b0;
        idle();
        rd(12, v); chk("mid_rst_status", v, 32'h00400000);
        rd(14, v); chk("mid_rst_epc", v, 32'h0);
        rd(8, v);  chk("mid_rst_badv", v, 32'h0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
